// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU memory-port controller.
package cpu_mem_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } stateT;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } ownerT;

endpackage

// File: rtl/mem_grant_sel.sv
// Fetch/data priority select with a starvation guard: data normally wins,
// but after MAX_STREAK data grants while fetch waits, fetch is forced.
module mem_grant_sel
   import cpu_mem_pkg::*;
#(
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic sampleEn,
   input  logic ifReq,
   input  logic dReq,
   output logic winnerData_c,
   output logic grantValid_c
);

   localparam int unsigned STREAK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] streak;
   logic [STREAK_W-1:0] streakNext;
   logic                fetchWins;

   // Priority decision and streak update for the current IDLE sample.
   always_comb begin
      streakNext   = streak;
      fetchWins    = ~dReq | (ifReq & (streak == STREAK_MAX));
      grantValid_c = sampleEn & (ifReq | dReq);
      winnerData_c = ~fetchWins;
      if (grantValid_c) begin
         if (fetchWins || !ifReq) begin
            streakNext = '0;
         end else if (streak != STREAK_MAX) begin
            streakNext = streak + STREAK_W'(1);
         end
      end
   end

   // Streak register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         streak <= '0;
      end else begin
         streak <= streakNext;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-port memory sequencer: arbitrates fetch vs data, runs one access at
// a time with an optional ready timeout, and holds the last read data.
module mem_access_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              timeout_seen,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   stateT            state, stateNext;
   ownerT            owner, ownerNext;
   logic [TO_W-1:0]  toCnt, toCntNext;
   logic             ifGntNext, ifDoneNext, dGntNext, dDoneNext, errNext;
   logic             timeoutSeenNext, memEnNext, memWeNext;
   logic [ADDR_W-1:0] memAddrNext;
   logic [DATA_W-1:0] memWdataNext, rdataNext;
   logic             winnerData_c, grantValid_c;

   mem_grant_sel #(
      .MAX_STREAK (MAX_STREAK)
   ) u_grant_sel (
      .clock        (clock),
      .reset        (reset),
      .sampleEn     (state == IDLE),
      .ifReq        (if_req),
      .dReq         (d_req),
      .winnerData_c (winnerData_c),
      .grantValid_c (grantValid_c)
   );

   // Next state and next values of every registered output.
   always_comb begin
      stateNext       = state;
      ownerNext       = owner;
      toCntNext       = toCnt;
      ifGntNext       = 1'b0;
      dGntNext        = 1'b0;
      ifDoneNext      = 1'b0;
      dDoneNext       = 1'b0;
      errNext         = 1'b0;
      timeoutSeenNext = timeout_seen;
      memEnNext       = mem_en;
      memWeNext       = mem_we;
      memAddrNext     = mem_addr;
      memWdataNext    = mem_wdata;
      rdataNext       = rdata;
      case (state)
         IDLE: begin
            if (grantValid_c) begin
               stateNext = ACCESS;
               memEnNext = 1'b1;
               toCntNext = '0;
               if (winnerData_c) begin
                  ownerNext    = OWN_D;
                  dGntNext     = 1'b1;
                  memWeNext    = d_we;
                  memAddrNext  = d_addr;
                  memWdataNext = d_wdata;
               end else begin
                  ownerNext   = OWN_IF;
                  ifGntNext   = 1'b1;
                  memWeNext   = 1'b0;
                  memAddrNext = if_addr;
               end
            end
         end
         ACCESS: begin
            toCntNext = toCnt + TO_W'(1);
            if (mem_ready) begin
               stateNext  = DONE;
               memEnNext  = 1'b0;
               memWeNext  = 1'b0;
               ifDoneNext = (owner == OWN_IF);
               dDoneNext  = (owner == OWN_D);
               if ((owner == OWN_IF) || !mem_we) begin
                  rdataNext = mem_rdata;
               end
            end else if ((TIMEOUT != 0) && (toCnt == TO_LAST)) begin
               stateNext       = DONE;
               memEnNext       = 1'b0;
               memWeNext       = 1'b0;
               ifDoneNext      = (owner == OWN_IF);
               dDoneNext       = (owner == OWN_D);
               errNext         = 1'b1;
               timeoutSeenNext = 1'b1;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         owner        <= OWN_IF;
         toCnt        <= '0;
         if_gnt       <= 1'b0;
         if_done      <= 1'b0;
         d_gnt        <= 1'b0;
         d_done       <= 1'b0;
         err          <= 1'b0;
         timeout_seen <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         rdata        <= '0;
      end else begin
         state        <= stateNext;
         owner        <= ownerNext;
         toCnt        <= toCntNext;
         if_gnt       <= ifGntNext;
         if_done      <= ifDoneNext;
         d_gnt        <= dGntNext;
         d_done       <= dDoneNext;
         err          <= errNext;
         timeout_seen <= timeoutSeenNext;
         mem_en       <= memEnNext;
         mem_we       <= memWeNext;
         mem_addr     <= memAddrNext;
         mem_wdata    <= memWdataNext;
         rdata        <= rdataNext;
      end
   end

endmodule
